spi_host: RTL and testbench



---
 rtl/spi_host.sv | 278 +++++++++++++++++++++++++++
 tb/tb_spi_host.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host.sv
// spi_host: memory-mapped SPI master (mode 0, MSB first) for the demo-system bus.
// Bus writes fill a small TX FIFO that is serialised on SCK/MOSI while MISO is
// sampled into a single RX holding register polled by software.
module spi_host #(
    parameter int unsigned TxFifoDepth = 4,
    parameter logic [15:0] ClkDivReset = 16'd24
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic        spi_cs_no
);

    localparam int unsigned PtrW = $clog2(TxFifoDepth) + 1;
    localparam int unsigned IdxW = PtrW - 1;

    localparam logic [1:0] RegTxData = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegRxData = 2'd2;
    localparam logic [1:0] RegCtrl   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_e;

    state_e state_q, state_d;

    // Bus decode
    logic [1:0] reg_sel;
    logic       wr_txdata, wr_status, wr_ctrl, rd_rxdata;

    assign reg_sel   = device_addr_i[3:2];
    assign wr_txdata = device_req_i && device_we_i && (reg_sel == RegTxData) && device_be_i[0];
    assign wr_status = device_req_i && device_we_i && (reg_sel == RegStatus);
    assign wr_ctrl   = device_req_i && device_we_i && (reg_sel == RegCtrl);
    assign rd_rxdata = device_req_i && !device_we_i && (reg_sel == RegRxData);

    // Address bits above the word index, upper byte enables and upper write
    // data are not decoded by this device.
    logic unused_bits;
    assign unused_bits = ^{device_addr_i[31:4], device_addr_i[1:0],
                           device_be_i[3:2], device_wdata_i[31:16]};

    // TX FIFO
    logic [7:0]      fifo_mem_q [TxFifoDepth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic            fifo_empty, fifo_full, push, pop, overflow_set;
    logic [7:0]      fifo_head;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                        (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
    assign fifo_head  = fifo_mem_q[rptr_q[IdxW-1:0]];
    // A pop on the same edge frees the slot, so a push into a full FIFO is
    // accepted when the FSM is taking the head at the same time.
    assign push         = wr_txdata && (!fifo_full || pop);
    assign overflow_set = wr_txdata && fifo_full && !pop;

    // FIFO storage write port
    // NOTE: storage has no reset; the pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wptr_q[IdxW-1:0]] <= device_wdata_i[7:0];
        end
    end

    // FIFO pointers, wrapping modulo 2*depth
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
        end
    end

    // Half-period timing
    logic [15:0] clkdiv_q, clkdiv_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tick;

    assign tick = (state_q != ST_IDLE) && (cnt_q == div_q);

    // CTRL byte-lane update, counter, and the divider copy used by the counter
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        clkdiv_d = clkdiv_q;
        if (wr_ctrl) begin
            if (device_be_i[0]) clkdiv_d[7:0]  = device_wdata_i[7:0];
            if (device_be_i[1]) clkdiv_d[15:8] = device_wdata_i[15:8];
        end
        // A new divisor only takes hold at a half-period boundary.
        div_d = ((state_q == ST_IDLE) || tick) ? clkdiv_q : div_q;
        if ((state_q == ST_IDLE) || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Timing registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clkdiv_q <= ClkDivReset;
            div_q    <= ClkDivReset;
            cnt_q    <= '0;
        end else begin
            clkdiv_q <= clkdiv_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
        end
    end

    // Shift datapath
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic       rx_load;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_SETUP;
            ST_SETUP: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: if (tick && sck_q && (bitcnt_q == 3'd7) && fifo_empty) state_d = ST_HOLD;
            ST_HOLD:  if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO pop, pin next values and shift-register updates
    always_comb begin
        pop        = 1'b0;
        rx_load    = 1'b0;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bitcnt_d   = bitcnt_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_head;
                    mosi_d     = fifo_head[7];
                    cs_n_d     = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tick) bitcnt_d = 3'd0;
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d      = 1'b1;
                        rx_shift_d = {rx_shift_q[6:0], spi_miso_i};
                    end else begin
                        sck_d      = 1'b0;
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        mosi_d     = tx_shift_q[6];
                        bitcnt_d   = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            rx_load = 1'b1;
                            // Back-to-back: the next byte follows with CS held low.
                            if (!fifo_empty) begin
                                pop        = 1'b1;
                                tx_shift_d = fifo_head;
                                mosi_d     = fifo_head[7];
                                bitcnt_d   = 3'd0;
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) cs_n_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Shift datapath and pin registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bitcnt_q   <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bitcnt_q   <= bitcnt_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
        end
    end

    // Status flags and RX holding register
    logic [7:0] rxdata_q;
    logic       rx_valid_q, overflow_q;

    // A freshly received byte wins over a simultaneous RXDATA read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxdata_q   <= '0;
            rx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (rx_load) begin
                rxdata_q   <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end else if (rd_rxdata) begin
                rx_valid_q <= 1'b0;
            end
            if (overflow_set)   overflow_q <= 1'b1;
            else if (wr_status) overflow_q <= 1'b0;
        end
    end

    // Bus read mux; writes and unmapped bits return zero
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = '0;
        if (device_req_i && !device_we_i) begin
            case (reg_sel)
                RegStatus: rdata_d = {27'd0, overflow_q, rx_valid_q,
                                      (state_q != ST_IDLE), fifo_empty, fifo_full};
                RegRxData: rdata_d = {24'd0, rxdata_q};
                RegCtrl:   rdata_d = {16'd0, clkdiv_q};
                default:   rdata_d = '0;
            endcase
        end
    end

    // Registered bus response, one cycle after every request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            device_rvalid_o <= 1'b0;
            device_rdata_o  <= '0;
        end else begin
            device_rvalid_o <= device_req_i;
            device_rdata_o  <= rdata_d;
        end
    end

    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_no  = cs_n_q;

endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: directed self-checking bench for spi_host with a mode-0 slave
// model that always answers 0x3C and a MOSI byte monitor.
module tb_spi_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        rvalid;
    logic [31:0] rdata;
    logic        sck, mosi, cs_n;
    logic        miso;

    int n_checks = 0;
    int n_pass   = 0;

    spi_host dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .device_req_i   (req),
        .device_addr_i  (addr),
        .device_we_i    (we),
        .device_be_i    (be),
        .device_wdata_i (wdata),
        .device_rvalid_o(rvalid),
        .device_rdata_o (rdata),
        .spi_sck_o      (sck),
        .spi_mosi_o     (mosi),
        .spi_miso_i     (miso),
        .spi_cs_no      (cs_n)
    );

    always #5 clk = ~clk;

    // SCK rising edges: count, timestamp, and assemble MOSI bytes
    int         rise_cnt = 0;
    int         mon_bits = 0;
    int         mon_cnt  = 0;
    logic [7:0] mon_sr   = 8'h00;
    logic [7:0] mon_bytes [64];
    time        last_rise_t = 0;
    time        prev_rise_t = 0;

    always @(posedge sck) begin
        rise_cnt++;
        prev_rise_t = last_rise_t;
        last_rise_t = $time;
        mon_sr = {mon_sr[6:0], mosi};
        mon_bits++;
        if (mon_bits == 8) begin
            if (mon_cnt < 64) mon_bytes[mon_cnt] = mon_sr;
            mon_cnt++;
            mon_bits = 0;
        end
    end

    // SCK falling edges
    int  fall_cnt = 0;
    time last_fall_t = 0;

    always @(negedge sck) begin
        fall_cnt++;
        last_fall_t = $time;
    end

    // CS rising edges
    int  cs_rise_cnt = 0;
    time cs_rise_t = 0;

    always @(posedge cs_n) begin
        cs_rise_cnt++;
        cs_rise_t = $time;
    end

    // Mode-0 slave: present bit 7 when CS falls, shift on each SCK fall,
    // reload the answer byte after every 8 falls
    logic [7:0] s_shift = 8'h00;
    int         s_cnt = 0;
    logic       cs_last = 1'b1;
    logic       sck_last = 1'b0;

    always @(cs_n or sck) begin
        if (cs_n !== cs_last) begin
            cs_last = cs_n;
            if (cs_n === 1'b0) begin
                s_shift = 8'h3C;
                s_cnt   = 0;
            end
        end
        if (sck !== sck_last) begin
            if (sck_last === 1'b1 && sck === 1'b0 && cs_n === 1'b0) begin
                s_cnt++;
                if (s_cnt == 8) begin
                    s_cnt   = 0;
                    s_shift = 8'h3C;
                end else begin
                    s_shift = {s_shift[6:0], 1'b0};
                end
            end
            sck_last = sck;
        end
        miso = s_shift[7];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One bus transaction; called at a falling clk edge, returns one cycle later
    task automatic bus(input logic w, input logic [1:0] r, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] q);
        req   = 1'b1;
        we    = w;
        addr  = {28'h0, r, 2'b00};
        wdata = d;
        be    = b;
        @(negedge clk);
        req   = 1'b0;
        we    = 1'b0;
        wdata = '0;
        be    = '0;
        check("rvalid", {31'd0, rvalid}, 32'd1);
        q = rdata;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] q;
        bus(1'b1, r, d, b, q);
        check("wr_rdata_zero", q, 32'd0);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] r, input logic [31:0] exp);
        logic [31:0] q;
        bus(1'b0, r, 32'd0, 4'h0, q);
        check(tag, q, exp);
    endtask

    task automatic wait_cs_rise(input string tag, input int base);
        for (int i = 0; i < 4000 && cs_rise_cnt == base; i++) @(negedge clk);
        check(tag, 32'(cs_rise_cnt - base), 32'd1);
    endtask

    int base_r, base_f, base_e, base_cs, base_mon;

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        be    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_cs", {31'd0, cs_n}, 32'd1);
        check("rst_sck", {31'd0, sck}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_rvalid", {31'd0, rvalid}, 32'd0);
        rd_check("status_reset", 2'd1, 32'h2);
        @(negedge clk);
        check("rvalid_drop", {31'd0, rvalid}, 32'd0);
        rd_check("ctrl_reset", 2'd3, 32'h18);
        rd_check("txdata_read", 2'd0, 32'h0);

        // Single byte 0xA5 at clkdiv=1
        wr(2'd3, 32'h0000_0001, 4'b0011);
        rd_check("ctrl_div1", 2'd3, 32'h1);
        base_cs  = cs_rise_cnt;
        base_mon = mon_cnt;
        wr(2'd0, 32'h0000_00A5, 4'b0001);
        wait_cs_rise("a5_done", base_cs);
        check("a5_count", 32'(mon_cnt - base_mon), 32'd1);
        check("a5_mosi", {24'd0, mon_bytes[base_mon]}, 32'hA5);
        check("sck_period", 32'(last_rise_t - prev_rise_t), 32'd40);
        check("cs_hold", 32'(cs_rise_t - last_fall_t), 32'd20);
        rd_check("status_rxv", 2'd1, 32'h0A);
        rd_check("rxdata_3c", 2'd2, 32'h3C);
        rd_check("status_rx_clr", 2'd1, 32'h02);

        // Three bytes back-to-back
        base_f   = fall_cnt;
        base_e   = rise_cnt + fall_cnt;
        base_cs  = cs_rise_cnt;
        base_mon = mon_cnt;
        wr(2'd0, 32'h11, 4'b0001);
        wr(2'd0, 32'h22, 4'b0001);
        wr(2'd0, 32'h33, 4'b0001);
        for (int i = 0; i < 2000 && fall_cnt < base_f + 24; i++) @(negedge clk);
        check("b2b_falls", 32'(fall_cnt - base_f), 32'd24);
        rd_check("status_hold_busy", 2'd1, 32'h0E);
        check("b2b_cs_low", {31'd0, cs_n}, 32'd0);
        check("b2b_no_gap", 32'(cs_rise_cnt - base_cs), 32'd0);
        check("b2b_edges", 32'(rise_cnt + fall_cnt - base_e), 32'd48);
        wait_cs_rise("b2b_done", base_cs);
        check("b2b_byte0", {24'd0, mon_bytes[base_mon]}, 32'h11);
        check("b2b_byte1", {24'd0, mon_bytes[base_mon + 1]}, 32'h22);
        check("b2b_byte2", {24'd0, mon_bytes[base_mon + 2]}, 32'h33);
        rd_check("b2b_rxdata", 2'd2, 32'h3C);
        rd_check("b2b_status", 2'd1, 32'h02);

        // Overflow with SCK stalled
        wr(2'd3, 32'h0000_FFFF, 4'b0011);
        rd_check("ctrl_stall", 2'd3, 32'hFFFF);
        for (int i = 1; i <= 6; i++) wr(2'd0, 32'(i), 4'b0001);
        rd_check("status_ovf", 2'd1, 32'h15);
        wr(2'd1, 32'h0, 4'b1111);
        rd_check("status_ovf_clr", 2'd1, 32'h05);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("stall_rst_status", 2'd1, 32'h02);

        // Push into a full FIFO on the same edge as the FSM pop
        wr(2'd3, 32'h0, 4'b0011);
        base_r   = rise_cnt;
        base_cs  = cs_rise_cnt;
        base_mon = mon_cnt;
        for (int i = 0; i < 5; i++) wr(2'd0, 32'hC1 + 32'(i), 4'b0001);
        for (int i = 0; i < 500 && rise_cnt < base_r + 8; i++) @(negedge clk);
        check("coinc_rises", 32'(rise_cnt - base_r), 32'd8);
        wr(2'd0, 32'hC6, 4'b0001);
        rd_check("status_coinc", 2'd1, 32'h0D);
        wait_cs_rise("coinc_done", base_cs);
        check("coinc_count", 32'(mon_cnt - base_mon), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("coinc_byte%0d", i), {24'd0, mon_bytes[base_mon + i]},
                  32'hC1 + 32'(i));
        end
        rd_check("coinc_no_ovf", 2'd1, 32'h0A);

        // Reset mid-byte with SCK high at bitcnt=3
        wr(2'd3, 32'h1, 4'b0011);
        base_r = rise_cnt;
        wr(2'd0, 32'h5A, 4'b0001);
        for (int i = 0; i < 500 && rise_cnt < base_r + 4; i++) @(negedge clk);
        check("mid_rises", 32'(rise_cnt - base_r), 32'd4);
        check("mid_sck_high", {31'd0, sck}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs", {31'd0, cs_n}, 32'd1);
        check("mid_rst_sck", {31'd0, sck}, 32'd0);
        check("mid_rst_mosi", {31'd0, mosi}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("mid_rst_status", 2'd1, 32'h02);
        rd_check("mid_rst_ctrl", 2'd3, 32'h18);
        base_r = rise_cnt;
        repeat (50) @(negedge clk);
        check("mid_rst_no_sck", 32'(rise_cnt - base_r), 32'd0);
        check("mid_rst_cs_idle", {31'd0, cs_n}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
